// File: rtl/prbs_train_send_if.sv
// Push/pull word channel from the BER pattern source into the send-side FIFO.
interface prbs_train_send_if;
  logic [63:0] DOUT;
  logic        DOPUSH;
  logic        DOPULL;

  modport master (output DOUT, output DOPUSH, input DOPULL);
  modport slave  (input DOUT, input DOPUSH, output DOPULL);
endinterface

// File: rtl/prbs_train_send.sv
// BER link-test transmitter: training words for alignment, then PRBS15 data
// 64 bits per transfer, with single-bit error injection and a sent-word count.
module prbs_train_send #(
  parameter logic [63:0] TRAIN_WORD = 64'hF0F0_F0F0_F0F0_F0F0,
  parameter int unsigned TRAIN_LEN  = 16,
  parameter logic [14:0] SEED       = 15'h7FFF,
  parameter int unsigned CNT_W      = 48
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             INJ_ERR,
  prbs_train_send_if.master tx,
  output logic             PHY_INIT,
  output logic             INJ_PEND,
  output logic [CNT_W-1:0] TX_CNT
);

  localparam int unsigned    TCW   = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [TCW-1:0] TLAST = TCW'(TRAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_DATA} state_t;

  state_t           state_q;
  logic [14:0]      lfsr_q;
  logic [TCW-1:0]   tcnt_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [63:0]      dout_q;
  logic             dopush_q;
  logic             phy_init_q;
  logic             inj_pend_q;
  logic             corr_q;

  logic [14:0] lfsr_d;
  logic [63:0] word_d;
  logic [14:0] s;
  logic        fb;
  logic        xfer;
  logic        last_train;
  logic        pend_d;

  // 64 serial LFSR steps unrolled; first step lands in bit 63.
  always_comb begin
    s      = lfsr_q;
    fb     = 1'b0;
    word_d = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      fb     = s[14] ^ s[13];
      word_d = {word_d[62:0], fb};
      s      = {s[13:0], fb};
    end
    lfsr_d = s;
  end

  always_comb begin
    xfer       = dopush_q & tx.DOPULL;
    last_train = (tcnt_q == TLAST);
    pend_d     = inj_pend_q;
    if (xfer && state_q == S_DATA && corr_q) pend_d = 1'b0;
    if (INJ_ERR && !inj_pend_q)              pend_d = 1'b1;
  end

  // The corruption mask is fixed when a word is loaded so a stalled word never
  // changes; corr_q remembers whether the presented word carries it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      tcnt_q     <= '0;
      tx_cnt_q   <= '0;
      dout_q     <= '0;
      dopush_q   <= 1'b0;
      phy_init_q <= 1'b0;
      inj_pend_q <= 1'b0;
      corr_q     <= 1'b0;
    end else if (CLR) begin
      lfsr_q     <= SEED;
      tcnt_q     <= '0;
      tx_cnt_q   <= '0;
      inj_pend_q <= 1'b0;
      corr_q     <= 1'b0;
      state_q    <= EN ? S_TRAIN : S_IDLE;
      dopush_q   <= EN;
      phy_init_q <= EN;
      if (EN) dout_q <= TRAIN_WORD;
    end else begin
      inj_pend_q <= pend_d;
      if (xfer && state_q == S_DATA && tx_cnt_q != '1)
        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      if (!EN) begin
        state_q    <= S_IDLE;
        dopush_q   <= 1'b0;
        phy_init_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q    <= S_TRAIN;
            tcnt_q     <= '0;
            dout_q     <= TRAIN_WORD;
            dopush_q   <= 1'b1;
            phy_init_q <= 1'b1;
          end
          S_TRAIN: begin
            if (xfer) begin
              if (last_train) begin
                state_q    <= S_DATA;
                phy_init_q <= 1'b0;
                dout_q     <= word_d ^ {{63{1'b0}}, pend_d};
                corr_q     <= pend_d;
                lfsr_q     <= lfsr_d;
              end else begin
                tcnt_q <= tcnt_q + TCW'(1);
              end
            end
          end
          S_DATA: begin
            if (xfer) begin
              dout_q <= word_d ^ {{63{1'b0}}, pend_d};
              corr_q <= pend_d;
              lfsr_q <= lfsr_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx.DOUT   = dout_q;
  assign tx.DOPUSH = dopush_q;
  assign PHY_INIT  = phy_init_q;
  assign INJ_PEND  = inj_pend_q;
  assign TX_CNT    = tx_cnt_q;

endmodule

// File: tb/tb_prbs_train_send.sv
// Scoreboard bench for prbs_train_send: stimulus pushes expected transfers,
// a monitor pops them on every observed handshake.
module tb_prbs_train_send;

  localparam int          TL   = 4;
  localparam logic [63:0] TW   = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [14:0] SEED = 15'h7FFF;

  logic        CLK;
  logic        RST, EN, CLR, INJ_ERR;
  logic        PHY_INIT, INJ_PEND;
  logic [47:0] TX_CNT;

  prbs_train_send_if tx_if();

  prbs_train_send #(.TRAIN_LEN(TL)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .INJ_ERR(INJ_ERR),
    .tx(tx_if), .PHY_INIT(PHY_INIT), .INJ_PEND(INJ_PEND), .TX_CNT(TX_CNT)
  );

  typedef struct { logic [63:0] d; logic phy; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  int          m_st, m_tc;
  logic [14:0] m_lfsr;
  logic        m_pend, m_corr;
  logic [47:0] m_txcnt;
  logic [63:0] m_word, m_clean;
  logic [47:0] saved_cnt;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bit-serial PRBS15 reference, x^15+x^14+1.
  task automatic ref_word(input logic [14:0] si, output logic [63:0] w, output logic [14:0] so);
    logic b;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      b = si[14] ^ si[13];
      w[63-i] = b;
      si = {si[13:0], b};
    end
    so = si;
  endtask

  task automatic load_word();
    logic [14:0] nx;
    ref_word(m_lfsr, m_clean, nx);
    m_lfsr = nx;
    m_corr = m_pend;
    m_word = m_clean ^ {{63{1'b0}}, m_pend};
  endtask

  // One clock: drive inputs on the falling edge, predict the rising edge,
  // return 1 time unit after it.
  task automatic cyc(input logic rst, input logic en, input logic clr,
                     input logic inj, input logic pull);
    logic xf, old_pend;
    exp_t e;
    @(negedge CLK);
    RST = rst; EN = en; CLR = clr; INJ_ERR = inj; tx_if.DOPULL = pull;
    xf = (m_st != 0) && pull;
    if (xf) begin
      e.d   = (m_st == 1) ? TW : m_word;
      e.phy = (m_st == 1);
      sb.push_back(e);
    end
    if (rst) begin
      m_st = 0; m_tc = 0; m_lfsr = SEED; m_pend = 0; m_corr = 0; m_txcnt = '0;
    end else if (clr) begin
      m_lfsr = SEED; m_txcnt = '0; m_tc = 0; m_pend = 0; m_corr = 0;
      m_st = en ? 1 : 0;
    end else begin
      old_pend = m_pend;
      if (xf && m_st == 2) begin
        if (m_txcnt != '1) m_txcnt++;
        if (m_corr) m_pend = 0;
      end
      if (inj && !old_pend) m_pend = 1;
      if (!en) m_st = 0;
      else if (m_st == 0) begin m_st = 1; m_tc = 0; end
      else if (xf) begin
        if (m_st == 1) begin
          m_tc++;
          if (m_tc == TL) begin m_st = 2; load_word(); end
        end else load_word();
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: transfers against the scoreboard, stalled words must hold.
  initial begin
    logic        p_push, p_pull, p_en, p_clr, p_rst;
    logic [63:0] p_dout;
    exp_t        e;
    p_push = 1'b0; p_pull = 1'b0; p_en = 1'b0; p_clr = 1'b0; p_rst = 1'b1; p_dout = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (p_push === 1'b1 && p_pull === 1'b0 && p_en === 1'b1 && p_clr === 1'b0 && p_rst === 1'b0)
        chk("stall_hold", {tx_if.DOPUSH, tx_if.DOUT[62:0]}, {1'b1, p_dout[62:0]});
      if (tx_if.DOPUSH === 1'b1 && tx_if.DOPULL === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_xfer: got %h expected none", tx_if.DOUT);
        end else begin
          e = sb.pop_front();
          chk("xfer_dout", tx_if.DOUT, e.d);
          chk("xfer_phy", 64'(PHY_INIT), 64'(e.phy));
        end
      end
      p_push = tx_if.DOPUSH; p_pull = tx_if.DOPULL; p_en = EN;
      p_clr = CLR; p_rst = RST; p_dout = tx_if.DOUT;
    end
  end

  initial begin
    int guard;
    RST = 1'b1; EN = 1'b0; CLR = 1'b0; INJ_ERR = 1'b0; tx_if.DOPULL = 1'b0;
    m_st = 0; m_tc = 0; m_lfsr = SEED; m_pend = 0; m_corr = 0; m_txcnt = '0;
    m_word = '0; m_clean = '0;

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_dout", tx_if.DOUT, 64'h0);
    chk("rst_push", 64'(tx_if.DOPUSH), 64'h0);
    chk("rst_phy", 64'(PHY_INIT), 64'h0);
    chk("rst_pend", 64'(INJ_PEND), 64'h0);
    chk("rst_cnt", 64'(TX_CNT), 64'h0);

    // Startup: one-cycle latency, 4 training words, then data
    cyc(0, 1, 0, 0, 1);
    chk("t1_push", 64'(tx_if.DOPUSH), 64'h1);
    chk("t1_train", tx_if.DOUT, 64'hF0F0_F0F0_F0F0_F0F0);
    chk("t1_phy", 64'(PHY_INIT), 64'h1);
    for (int i = 0; i < TL; i++) cyc(0, 1, 0, 0, 1);
    chk("t1_phy_off", 64'(PHY_INIT), 64'h0);
    chk("t1_first", 64'(tx_if.DOUT[63:48]), 64'h0002);
    cyc(0, 1, 0, 0, 1);
    chk("t1_cnt1", 64'(TX_CNT), 64'd1);

    // Random backpressure up to 1000 data words
    guard = 0;
    while (m_txcnt < 48'd1000 && guard < 20000) begin
      cyc(0, 1, 0, 0, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("t2_cnt1000", 64'(TX_CNT), 64'd1000);

    // Error injection; second pulse lands while still pending
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 1, 1);
    chk("t3_pend", 64'(INJ_PEND), 64'h1);
    chk("t3_bit0", tx_if.DOUT ^ m_clean, 64'h1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    chk("t3_pend_hold", 64'(INJ_PEND), 64'h1);
    chk("t3_bit0_hold", tx_if.DOUT ^ m_clean, 64'h1);
    cyc(0, 1, 0, 0, 1);
    chk("t3_pend_clr", 64'(INJ_PEND), 64'h0);
    chk("t3_next_clean", tx_if.DOUT, m_clean);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1);
    chk("t3_pend_stay", 64'(INJ_PEND), 64'h0);

    // CLR while a data word is stalled
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("t4_train", tx_if.DOUT, 64'hF0F0_F0F0_F0F0_F0F0);
    chk("t4_phy", 64'(PHY_INIT), 64'h1);
    chk("t4_cnt0", 64'(TX_CNT), 64'h0);
    for (int i = 0; i < TL; i++) cyc(0, 1, 0, 0, 1);
    chk("t4_first", 64'(tx_if.DOUT[63:48]), 64'h0002);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1);

    // EN drop for 5 cycles, then resume
    cyc(0, 0, 0, 0, 1);
    saved_cnt = m_txcnt;
    chk("t5_idle0", 64'(tx_if.DOPUSH), 64'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("t5_idle", 64'(tx_if.DOPUSH), 64'h0);
    end
    chk("t5_cnt_kept", 64'(TX_CNT), 64'(saved_cnt));
    cyc(0, 1, 0, 0, 1);
    chk("t5_retrain", 64'(PHY_INIT), 64'h1);
    for (int i = 0; i < TL; i++) cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1);
    chk("t5_cnt_cont", 64'(TX_CNT), 64'(saved_cnt + 48'd3));

    // RST mid-training with an armed injection
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, 1);
    chk("t6_pend", 64'(INJ_PEND), 64'h1);
    chk("t6_phy", 64'(PHY_INIT), 64'h1);
    cyc(1, 1, 0, 0, 0);
    chk("t6_dout", tx_if.DOUT, 64'h0);
    chk("t6_push", 64'(tx_if.DOPUSH), 64'h0);
    chk("t6_phy0", 64'(PHY_INIT), 64'h0);
    chk("t6_pend0", 64'(INJ_PEND), 64'h0);
    chk("t6_cnt0", 64'(TX_CNT), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("t6_idle", 64'(tx_if.DOPUSH), 64'h0);
    end

    @(negedge CLK);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
